serpent_lt_pipe: RTL and testbench
==================================

// Module: serpent_lt_pipe
// PURPOSE
//   Pipelined, parametrised Serpent linear transform (LT) supporting forward (encrypt) and
//   inverse (decrypt) modes per beat, over LANES independent 128-bit blocks per beat.
//   It sits between the bitsliced S-box stage and the round-key XOR in the XTS round datapath.
//   A valid/ready handshake with a tag passthrough lets the round controller interleave sectors.
// PARAMETERS
//   LANES   1  number of 128-bit blocks transformed per beat (1..4)
//   STAGES  1  pipeline depth: 1 = one register after full LT; 2 = extra register mid-LT
//   TAG_W   8  width of opaque sideband tag carried alongside each beat
// PORTS
//   i_clk    in   1          clock; all logic on rising edge
//   i_rst    in   1          synchronous, active-high reset
//   i_valid  in   1          input beat valid
//   o_ready  out  1          block accepts input this cycle
//   i_inv    in   1          0 = forward LT, 1 = inverse LT (sampled with beat)
//   i_tag    in   TAG_W      sideband tag, returned unchanged with the beat
//   i_data   in   128*LANES  lane n at [128n+127:128n]; word k of lane at [128n+32k+31:128n+32k]
//   o_valid  out  1          output beat valid
//   i_ready  in   1          downstream accepts output
//   o_data   out  128*LANES  transformed data, same packing as i_data
//   o_tag    out  TAG_W      tag of the output beat
// BEHAVIOUR
//   - Reset: o_valid=0, all stage valid bits 0, o_data=0, o_tag=0; o_ready=1 on the cycle after reset.
//   - Forward LT on words X0..X3: X0=ROL13(X0); X2=ROL3(X2); X1^=X0^X2; X3^=X2^(X0<<3);
//     X1=ROL1(X1); X3=ROL7(X3); X0^=X1^X3; X2^=X3^(X1<<7); X0=ROL5(X0); X2=ROL22(X2).
//   - Inverse LT: X2=ROR22(X2); X0=ROR5(X0); X2^=X3^(X1<<7); X0^=X1^X3; X3=ROR7(X3);
//     X1=ROR1(X1); X3^=X2^(X0<<3); X1^=X0^X2; X2=ROR3(X2); X0=ROR13(X0).
//   - Shifts are logical, 32-bit, bits shifted out discarded; all XOR/rotates 32-bit modular.
//   - Lanes are fully independent; all lanes of a beat use the same i_inv.
//   - STAGES=2 split point: forward after the X1/X3 ROL1/ROL7 step; inverse after the X3/X1
//     ROR7/ROR1 step. Mode bit and tag travel with the beat through every stage.
//   - Handshake: transfer in when i_valid&&o_ready; out when o_valid&&i_ready.
//   - Global advance enable en = !o_valid || i_ready; o_ready = en. All stages load on en.
//   - Latency: exactly STAGES cycles from accept to o_valid with continuous i_ready;
//     throughput one beat per cycle. Bubbles are not compressed (stage moves as a whole).
//   - Stall: while o_valid && !i_ready, o_data/o_tag/o_valid hold stable; no beat lost or duplicated.
//   - i_data/i_inv/i_tag ignored when i_valid=0; stage valid loads 0 on en with no input.
//   - Same-cycle accept and drain under en is legal and required at full rate.
//   - Reset mid-operation: all in-flight beats discarded, no output produced for them.
//   - STAGES outside {1,2} or LANES outside 1..4: elaboration error.
// STRUCTURE
//   - Shared package serpent_pkg: SERPENT_BLK_W=128, SERPENT_WORD_W=32, rotate constants
//     (13,3,1,7,5,22), shift constants (3,7), rol32/ror32 functions.
//   - Sub-module serpent_lt_half: combinational one-half LT for one lane (inputs: 4 words,
//     half select, inv); instantiated 2*LANES times. Top holds stage regs and handshake.
// TESTING
//   - Fwd, lane0 words {w0=0x00000001,w1=0,w2=0,w3=0}, inv=0 -> o_data words
//     {0x100C0000,0x00004000,0x00002800,0x00800000} after STAGES cycles.
//   - Inverse of that output with inv=1 -> {0x00000001,0,0,0}; all-zero input -> all-zero output.
//   - Random 1000 beats, mixed inv, LANES=4, STAGES=1 and 2, i_ready always 1 -> matches
//     reference model, one output per cycle, latency == STAGES, tags in order.
//   - i_ready toggled randomly 50% -> no loss/duplication, o_data stable while stalled,
//     o_ready == !o_valid || i_ready every cycle.
//   - Assert i_rst with 2 beats in flight (STAGES=2) -> next cycle o_valid=0, o_data=0, o_tag=0,
//     and none of those beats ever appear on output.
//   - Back-to-back fwd then inv beats, tags 0x11/0x22 -> outputs in order with tags 0x11,0x22.

Source files
------------

// File: rtl/serpent_pkg.sv
// Shared Serpent constants and 32-bit rotate helpers used by the linear-transform datapath.
package serpent_pkg;

    localparam int SERPENT_BLK_W  = 128;
    localparam int SERPENT_WORD_W = 32;

    // Rotate amounts in the order they appear in the forward transform
    localparam int unsigned LT_ROT_X0_A = 13;
    localparam int unsigned LT_ROT_X2_A = 3;
    localparam int unsigned LT_ROT_X1   = 1;
    localparam int unsigned LT_ROT_X3   = 7;
    localparam int unsigned LT_ROT_X0_B = 5;
    localparam int unsigned LT_ROT_X2_B = 22;
    localparam int unsigned LT_SHL_X0   = 3;
    localparam int unsigned LT_SHL_X1   = 7;

    typedef logic [SERPENT_WORD_W-1:0] word_t;

    // Which half of the transform a serpent_lt_half instance computes
    typedef enum logic {
        HALF_A = 1'b0,
        HALF_B = 1'b1
    } lt_half_e;

    function automatic word_t rol32(input word_t x, input int unsigned n);
        return (x << n) | (x >> (SERPENT_WORD_W - n));
    endfunction

    function automatic word_t ror32(input word_t x, input int unsigned n);
        return (x >> n) | (x << (SERPENT_WORD_W - n));
    endfunction

endpackage

// File: rtl/serpent_lt_half.sv
// Combinational half of the Serpent linear transform for one 128-bit lane.
// HALF_A ends after the X1/X3 rotate step (forward) or the X3/X1 rotate step (inverse).
module serpent_lt_half
    import serpent_pkg::*;
(
    input  logic [SERPENT_BLK_W-1:0] blk,
    input  logic                     half_sel,
    input  logic                     inv,
    output logic [SERPENT_BLK_W-1:0] res
);

    word_t x0, x1, x2, x3;

    // NOTE: blocking assignments are intended here; each step reads the word updated by the
    // previous one, and every word is assigned up front so no latch can be inferred.
    always_comb begin
        x0 = blk[0*SERPENT_WORD_W +: SERPENT_WORD_W];
        x1 = blk[1*SERPENT_WORD_W +: SERPENT_WORD_W];
        x2 = blk[2*SERPENT_WORD_W +: SERPENT_WORD_W];
        x3 = blk[3*SERPENT_WORD_W +: SERPENT_WORD_W];

        if (!inv && half_sel == HALF_A) begin
            x0 = rol32(x0, LT_ROT_X0_A);
            x2 = rol32(x2, LT_ROT_X2_A);
            x1 = x1 ^ x0 ^ x2;
            x3 = x3 ^ x2 ^ (x0 << LT_SHL_X0);
            x1 = rol32(x1, LT_ROT_X1);
            x3 = rol32(x3, LT_ROT_X3);
        end else if (!inv) begin
            x0 = x0 ^ x1 ^ x3;
            x2 = x2 ^ x3 ^ (x1 << LT_SHL_X1);
            x0 = rol32(x0, LT_ROT_X0_B);
            x2 = rol32(x2, LT_ROT_X2_B);
        end else if (half_sel == HALF_A) begin
            x2 = ror32(x2, LT_ROT_X2_B);
            x0 = ror32(x0, LT_ROT_X0_B);
            x2 = x2 ^ x3 ^ (x1 << LT_SHL_X1);
            x0 = x0 ^ x1 ^ x3;
            x3 = ror32(x3, LT_ROT_X3);
            x1 = ror32(x1, LT_ROT_X1);
        end else begin
            x3 = x3 ^ x2 ^ (x0 << LT_SHL_X0);
            x1 = x1 ^ x0 ^ x2;
            x2 = ror32(x2, LT_ROT_X2_A);
            x0 = ror32(x0, LT_ROT_X0_A);
        end

        res = {x3, x2, x1, x0};
    end

endmodule

// File: rtl/serpent_lt_pipe.sv
// Pipelined forward/inverse Serpent linear transform over LANES blocks per beat, with a
// valid/ready handshake and an opaque tag that travels with each beat.
module serpent_lt_pipe
    import serpent_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int STAGES = 1,
    parameter int TAG_W  = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic                           i_inv,
    input  logic [TAG_W-1:0]               i_tag,
    input  logic [SERPENT_BLK_W*LANES-1:0] i_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [SERPENT_BLK_W*LANES-1:0] o_data,
    output logic [TAG_W-1:0]               o_tag
);

    localparam int DATA_W = SERPENT_BLK_W * LANES;

    if (STAGES < 1 || STAGES > 2 || LANES < 1 || LANES > 4) begin : g_bad_params
        $error("serpent_lt_pipe: STAGES must be 1 or 2 and LANES must be 1..4");
    end

    logic              en;
    logic [DATA_W-1:0] mid_data;
    logic [DATA_W-1:0] tail_in;
    logic [DATA_W-1:0] tail_data;
    logic              tail_valid;
    logic              tail_inv;
    logic [TAG_W-1:0]  tail_tag;

    // The whole pipe advances together; an empty output slot or a draining one frees it
    assign en      = !o_valid || i_ready;
    assign o_ready = en;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        serpent_lt_half u_head (
            .blk      (i_data[l*SERPENT_BLK_W +: SERPENT_BLK_W]),
            .half_sel (HALF_A),
            .inv      (i_inv),
            .res      (mid_data[l*SERPENT_BLK_W +: SERPENT_BLK_W])
        );

        serpent_lt_half u_tail (
            .blk      (tail_in[l*SERPENT_BLK_W +: SERPENT_BLK_W]),
            .half_sel (HALF_B),
            .inv      (tail_inv),
            .res      (tail_data[l*SERPENT_BLK_W +: SERPENT_BLK_W])
        );
    end

    if (STAGES == 2) begin : g_mid_reg
        logic              s1_valid;
        logic              s1_inv;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_data;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                s1_valid <= 1'b0;
                s1_inv   <= 1'b0;
                s1_tag   <= '0;
                s1_data  <= '0;
            end else if (en) begin
                s1_valid <= i_valid;
                s1_inv   <= i_inv;
                s1_tag   <= i_tag;
                s1_data  <= mid_data;
            end
        end

        assign tail_in    = s1_data;
        assign tail_valid = s1_valid;
        assign tail_inv   = s1_inv;
        assign tail_tag   = s1_tag;
    end else begin : g_direct
        assign tail_in    = mid_data;
        assign tail_valid = i_valid;
        assign tail_inv   = i_inv;
        assign tail_tag   = i_tag;
    end

    // NOTE: data and tag registers are reset too, because the output bus must read as zero
    // after reset rather than showing stale or undefined contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_tag   <= '0;
        end else if (en) begin
            o_valid <= tail_valid;
            o_data  <= tail_data;
            o_tag   <= tail_tag;
        end
    end

endmodule

// File: tb/tb_serpent_lt_pipe.sv
// Self-checking bench: one LANES=4 pipe with STAGES=1 and one with STAGES=2, run in turn.
module tb_serpent_lt_pipe;

    localparam int LANES = 4;
    localparam int TAG_W = 8;
    localparam int DW    = 128 * LANES;

    typedef struct {
        int           lane;
        logic         inv;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [DW-1:0]    data;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_valid  [2];
    logic             in_inv    [2];
    logic             in_ready  [2];
    logic             out_ready [2];
    logic             out_valid [2];
    logic [TAG_W-1:0] in_tag    [2];
    logic [TAG_W-1:0] out_tag   [2];
    logic [DW-1:0]    in_data   [2];
    logic [DW-1:0]    out_data  [2];

    int total = 0;
    int bad   = 0;

    serpent_lt_pipe #(.LANES(LANES), .STAGES(1), .TAG_W(TAG_W)) dut_s1 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid[0]),
        .o_ready (out_ready[0]),
        .i_inv   (in_inv[0]),
        .i_tag   (in_tag[0]),
        .i_data  (in_data[0]),
        .o_valid (out_valid[0]),
        .i_ready (in_ready[0]),
        .o_data  (out_data[0]),
        .o_tag   (out_tag[0])
    );

    serpent_lt_pipe #(.LANES(LANES), .STAGES(2), .TAG_W(TAG_W)) dut_s2 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid[1]),
        .o_ready (out_ready[1]),
        .i_inv   (in_inv[1]),
        .i_tag   (in_tag[1]),
        .i_data  (in_data[1]),
        .o_valid (out_valid[1]),
        .i_ready (in_ready[1]),
        .o_data  (out_data[1]),
        .o_tag   (out_tag[1])
    );

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: the transform computed directly from its definition, whole-block.
    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] rr(input logic [31:0] v, input int n);
        return (v >> n) | (v << (32 - n));
    endfunction

    function automatic logic [127:0] ref_lt(input logic [127:0] b, input logic inv);
        logic [31:0] x [4];
        for (int k = 0; k < 4; k++) x[k] = b[32*k +: 32];
        if (!inv) begin
            x[0] = rl(x[0], 13);  x[2] = rl(x[2], 3);
            x[1] = x[1] ^ x[0] ^ x[2];
            x[3] = x[3] ^ x[2] ^ (x[0] << 3);
            x[1] = rl(x[1], 1);   x[3] = rl(x[3], 7);
            x[0] = x[0] ^ x[1] ^ x[3];
            x[2] = x[2] ^ x[3] ^ (x[1] << 7);
            x[0] = rl(x[0], 5);   x[2] = rl(x[2], 22);
        end else begin
            x[2] = rr(x[2], 22);  x[0] = rr(x[0], 5);
            x[2] = x[2] ^ x[3] ^ (x[1] << 7);
            x[0] = x[0] ^ x[1] ^ x[3];
            x[3] = rr(x[3], 7);   x[1] = rr(x[1], 1);
            x[3] = x[3] ^ x[2] ^ (x[0] << 3);
            x[1] = x[1] ^ x[0] ^ x[2];
            x[2] = rr(x[2], 3);   x[0] = rr(x[0], 13);
        end
        return {x[3], x[2], x[1], x[0]};
    endfunction

    function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        for (int l = 0; l < LANES; l++) r[128*l +: 128] = ref_lt(d[128*l +: 128], inv);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic run_vectors(input int d);
        vec_t          vt [5];
        logic [DW-1:0] din, exp;
        int            hit_cyc, hits;
        vt[0] = '{lane: 0, inv: 1'b0, din: 128'h1,
                  exp: {32'h00800000, 32'h00002800, 32'h00004000, 32'h100C0000}};
        vt[1] = '{lane: 0, inv: 1'b1,
                  din: {32'h00800000, 32'h00002800, 32'h00004000, 32'h100C0000}, exp: 128'h1};
        vt[2] = '{lane: 1, inv: 1'b0, din: 128'h0, exp: 128'h0};
        vt[3] = '{lane: 2, inv: 1'b1, din: 128'h0, exp: 128'h0};
        vt[4] = '{lane: 3, inv: 1'b0, din: 128'h1,
                  exp: {32'h00800000, 32'h00002800, 32'h00004000, 32'h100C0000}};
        for (int v = 0; v < 5; v++) begin
            din = '0;
            exp = '0;
            din[128*vt[v].lane +: 128] = vt[v].din;
            exp[128*vt[v].lane +: 128] = vt[v].exp;
            @(posedge clk); #1;
            in_valid[d] = 1'b1;
            in_data[d]  = din;
            in_inv[d]   = vt[v].inv;
            in_tag[d]   = TAG_W'(8'h40 + v);
            in_ready[d] = 1'b1;
            hits    = 0;
            hit_cyc = -1;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                in_valid[d] = 1'b0;
                if (out_valid[d]) begin
                    if (hits == 0) begin
                        hit_cyc = i;
                        check("vec_data", out_data[d], exp);
                        check("vec_tag", DW'(out_tag[d]), DW'(8'h40 + v));
                    end
                    hits++;
                end
            end
            check("vec_latency", DW'(hit_cyc), DW'(d));
            check("vec_count", DW'(hits), DW'(1));
        end
    endtask

    task automatic back_to_back(input int d);
        logic [DW-1:0]    da, db;
        logic [DW-1:0]    got_d [2];
        logic [TAG_W-1:0] got_t [2];
        int               got_c [2];
        int               n;
        da = rand_data();
        db = rand_data();
        n  = 0;
        @(posedge clk); #1;
        in_ready[d] = 1'b1;
        in_valid[d] = 1'b1; in_data[d] = da; in_inv[d] = 1'b0; in_tag[d] = 8'h11;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                in_data[d] = db; in_inv[d] = 1'b1; in_tag[d] = 8'h22;
            end else begin
                in_valid[d] = 1'b0;
            end
            if (out_valid[d]) begin
                if (n < 2) begin
                    got_d[n] = out_data[d];
                    got_t[n] = out_tag[d];
                    got_c[n] = i;
                end
                n++;
            end
        end
        check("b2b_count", DW'(n), DW'(2));
        if (n >= 2) begin
            check("b2b_tag0", DW'(got_t[0]), DW'(8'h11));
            check("b2b_tag1", DW'(got_t[1]), DW'(8'h22));
            check("b2b_data0", got_d[0], ref_beat(da, 1'b0));
            check("b2b_data1", got_d[1], ref_beat(db, 1'b1));
            check("b2b_first_cyc", DW'(got_c[0]), DW'(d));
            check("b2b_back_to_back", DW'(got_c[1]), DW'(got_c[0] + 1));
        end
    endtask

    task automatic run_stream(input int d, input int n_beats, input bit full_rate);
        exp_t             q [$];
        exp_t             e;
        logic [DW-1:0]    held_d, nd;
        logic [TAG_W-1:0] held_t, tag_ctr;
        logic             ni;
        bit               stalled, have;
        int               sent, cyc, budget;
        sent    = 0;
        cyc     = 0;
        stalled = 1'b0;
        have    = 1'b0;
        tag_ctr = '0;
        budget  = n_beats * 8 + 50;
        held_d  = '0;
        held_t  = '0;
        nd      = '0;
        ni      = 1'b0;
        while ((sent < n_beats || q.size() > 0) && cyc < budget) begin
            @(posedge clk); #1;
            if (!have && sent < n_beats) begin
                nd   = rand_data();
                ni   = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            in_valid[d] = have && (full_rate || $urandom_range(0, 3) != 0);
            in_data[d]  = nd;
            in_inv[d]   = ni;
            in_tag[d]   = tag_ctr;
            in_ready[d] = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("ready_rule", DW'(out_ready[d]), DW'(!out_valid[d] || in_ready[d]));
            if (stalled) begin
                check("stall_valid", DW'(out_valid[d]), DW'(1));
                check("stall_data", out_data[d], held_d);
                check("stall_tag", DW'(out_tag[d]), DW'(held_t));
            end
            if (out_valid[d] && in_ready[d]) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", DW'(1), DW'(0));
                end else begin
                    e = q.pop_front();
                    check("stream_data", out_data[d], e.data);
                    check("stream_tag", DW'(out_tag[d]), DW'(e.tag));
                    if (full_rate) check("stream_latency", DW'(cyc - e.cyc), DW'(d + 1));
                end
            end
            stalled = out_valid[d] && !in_ready[d];
            held_d  = out_data[d];
            held_t  = out_tag[d];
            if (in_valid[d] && out_ready[d]) begin
                q.push_back('{data: ref_beat(nd, ni), tag: tag_ctr, cyc: cyc});
                sent++;
                tag_ctr++;
                have = 1'b0;
            end
            cyc++;
        end
        check("stream_sent", DW'(sent), DW'(n_beats));
        check("stream_drained", DW'(q.size()), DW'(0));
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_ready[d] = 1'b1;
    endtask

    task automatic reset_in_flight(input int d);
        @(posedge clk); #1;
        in_ready[d] = 1'b1;
        in_valid[d] = 1'b1; in_data[d] = rand_data(); in_inv[d] = 1'b0; in_tag[d] = 8'hA1;
        @(posedge clk); #1;
        in_data[d] = rand_data(); in_inv[d] = 1'b1; in_tag[d] = 8'hA2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid[d] = 1'b0;
        check("rst_valid", DW'(out_valid[d]), DW'(0));
        check("rst_data", out_data[d], '0);
        check("rst_tag", DW'(out_tag[d]), DW'(0));
        check("rst_ready", DW'(out_ready[d]), DW'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rst_no_ghost", DW'(out_valid[d]), DW'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0;
            in_inv[d]   = 1'b0;
            in_ready[d] = 1'b1;
            in_tag[d]   = '0;
            in_data[d]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("reset_valid", DW'(out_valid[d]), DW'(0));
            check("reset_data", out_data[d], '0);
            check("reset_tag", DW'(out_tag[d]), DW'(0));
            check("reset_ready", DW'(out_ready[d]), DW'(1));
        end
        for (int d = 0; d < 2; d++) begin
            run_vectors(d);
            back_to_back(d);
            run_stream(d, 1000, 1'b1);
            run_stream(d, 300, 1'b0);
        end
        reset_in_flight(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
